// File: rtl/bf16_arith_unit.sv
// Registered bfloat16 add/sub/mul/div unit: combinational datapath, one output register stage.
// Subnormal inputs read as signed zero; results are RNE-rounded with flush-to-zero.
module bf16_arith_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] out
);

  localparam logic [15:0] CanonNan = 16'h7FC0;

  // Round-to-nearest-even on an 8-bit significand, then overflow/underflow clamp.
  function automatic logic [15:0] round_pack(input logic s, input logic signed [10:0] e,
                                             input logic [7:0] m, input logic g,
                                             input logic st);
    logic [8:0]         m_r;
    logic signed [10:0] e_r;
    m_r = {1'b0, m} + {8'b0, g & (st | m[0])};
    e_r = e + $signed({10'b0, m_r[8]});
    if (e_r >= 11'sd255)    round_pack = {s, 15'h7F80};
    else if (e_r <= 11'sd0) round_pack = {s, 15'h0000};
    else                    round_pack = {s, e_r[7:0], m_r[6:0]};
  endfunction

  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd11;
    for (int i = 0; i < 11; i++) if (v[i]) lzc11 = 4'(10 - i);
  endfunction

  logic        w_sa, w_sb;
  logic [7:0]  w_ea, w_eb, w_ma, w_mb;
  logic        w_za, w_zb, w_ia, w_ib, w_na, w_nb;

  assign w_sa = a[15];
  assign w_sb = b[15] ^ (op == 2'b01);
  assign w_ea = a[14:7];
  assign w_eb = b[14:7];
  assign w_ma = {1'b1, a[6:0]};
  assign w_mb = {1'b1, b[6:0]};
  assign w_za = (w_ea == 8'h00);
  assign w_zb = (w_eb == 8'h00);
  assign w_ia = (w_ea == 8'hFF) && (a[6:0] == 7'h00);
  assign w_ib = (w_eb == 8'hFF) && (b[6:0] == 7'h00);
  assign w_na = (w_ea == 8'hFF) && (a[6:0] != 7'h00);
  assign w_nb = (w_eb == 8'hFF) && (b[6:0] != 7'h00);

  // Add: X is the larger magnitude operand, Y is aligned to it with G/R/S bits.
  logic [14:0] w_mag_a, w_mag_b;
  logic        w_swap, w_sx, w_sy;
  logic [7:0]  w_ex, w_ey, w_mx, w_my, w_d;
  logic [10:0] w_y_ext, w_y_sh, w_norm;
  logic [11:0] w_sum;
  logic [3:0]  w_lz;

  assign w_mag_a = w_za ? 15'h0 : a[14:0];
  assign w_mag_b = w_zb ? 15'h0 : b[14:0];
  assign w_swap  = w_mag_b > w_mag_a;
  assign w_sx    = w_swap ? w_sb : w_sa;
  assign w_sy    = w_swap ? w_sa : w_sb;
  assign w_ex    = w_swap ? w_eb : w_ea;
  assign w_ey    = w_swap ? w_ea : w_eb;
  assign w_mx    = w_swap ? (w_zb ? 8'h00 : w_mb) : (w_za ? 8'h00 : w_ma);
  assign w_my    = w_swap ? (w_za ? 8'h00 : w_ma) : (w_zb ? 8'h00 : w_mb);
  assign w_d     = w_ex - w_ey;
  assign w_y_ext = {w_my, 3'b000};

  always_comb begin
    w_y_sh = 11'h000;
    if (w_d >= 8'd11) w_y_sh = {10'b0, |w_my};
    else w_y_sh = (w_y_ext >> w_d[3:0]) | {10'b0, |(w_y_ext & ~(11'h7FF << w_d[3:0]))};
  end

  assign w_sum  = (w_sx == w_sy) ? ({1'b0, w_mx, 3'b000} + {1'b0, w_y_sh})
                                 : ({1'b0, w_mx, 3'b000} - {1'b0, w_y_sh});
  assign w_lz   = lzc11(w_sum[10:0]);
  assign w_norm = w_sum[10:0] << w_lz;

  logic signed [10:0] w_add_e;
  logic [7:0]         w_add_m;
  logic               w_add_g, w_add_st;

  always_comb begin
    if (w_sum[11]) begin
      w_add_m  = w_sum[11:4];
      w_add_g  = w_sum[3];
      w_add_st = |w_sum[2:0];
      w_add_e  = $signed({3'b000, w_ex}) + 11'sd1;
    end else begin
      w_add_m  = w_norm[10:3];
      w_add_g  = w_norm[2];
      w_add_st = |w_norm[1:0];
      w_add_e  = $signed({3'b000, w_ex}) - $signed({7'b0, w_lz});
    end
  end

  // Mul: 8x8 significand product lies in [1,4).
  logic [15:0]        w_prod;
  logic signed [10:0] w_mul_e;

  assign w_prod  = {8'b0, w_ma} * {8'b0, w_mb};
  assign w_mul_e = $signed({3'b000, w_ea}) + $signed({3'b000, w_eb}) - 11'sd127
                   + $signed({10'b0, w_prod[15]});

  // Div: restoring divide, 10 quotient bits cover both the [1,2) and (0.5,1) cases.
  logic [9:0]         w_q;
  logic [8:0]         w_rem;
  logic signed [10:0] w_div_e;

  always_comb begin
    w_q   = 10'h000;
    w_rem = {1'b0, w_ma};
    for (int i = 9; i >= 0; i--) begin
      if (w_rem >= {1'b0, w_mb}) begin
        w_q[i] = 1'b1;
        w_rem  = w_rem - {1'b0, w_mb};
      end
      if (i > 0) w_rem = w_rem << 1;
    end
  end

  assign w_div_e = $signed({3'b000, w_ea}) - $signed({3'b000, w_eb}) + 11'sd126
                   + $signed({10'b0, w_q[9]});

  logic        w_sp;
  logic [15:0] w_result;

  assign w_sp = w_sa ^ w_sb;

  always_comb begin
    w_result = 16'h0000;
    if (w_na || w_nb) begin
      w_result = CanonNan;
    end else begin
      unique case (op)
        2'b00, 2'b01: begin
          if (w_ia && w_ib && (w_sa != w_sb)) w_result = CanonNan;
          else if (w_ia)           w_result = {w_sa, 15'h7F80};
          else if (w_ib)           w_result = {w_sb, 15'h7F80};
          else if (w_sum == 12'h0) w_result = {w_sx & w_sy, 15'h0000};
          else w_result = round_pack(w_sx, w_add_e, w_add_m, w_add_g, w_add_st);
        end
        2'b10: begin
          if ((w_ia && w_zb) || (w_za && w_ib)) w_result = CanonNan;
          else if (w_ia || w_ib)           w_result = {w_sp, 15'h7F80};
          else if (w_za || w_zb)           w_result = {w_sp, 15'h0000};
          else if (w_prod[15])
            w_result = round_pack(w_sp, w_mul_e, w_prod[15:8], w_prod[7], |w_prod[6:0]);
          else
            w_result = round_pack(w_sp, w_mul_e, w_prod[14:7], w_prod[6], |w_prod[5:0]);
        end
        2'b11: begin
          if ((w_za && w_zb) || (w_ia && w_ib)) w_result = CanonNan;
          else if (w_zb || w_ia)           w_result = {w_sp, 15'h7F80};
          else if (w_ib || w_za)           w_result = {w_sp, 15'h0000};
          else if (w_q[9])
            w_result = round_pack(w_sp, w_div_e, w_q[9:2], w_q[1], w_q[0] | (|w_rem));
          else
            w_result = round_pack(w_sp, w_div_e, w_q[8:1], w_q[0], |w_rem);
        end
      endcase
    end
  end

  logic        r_out_valid;
  logic [15:0] r_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= 16'h0000;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) r_out <= w_result;
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;

endmodule

// File: tb/tb_bf16_arith_unit.sv
// Bench for bf16_arith_unit: directed cases plus random vectors against a real-arithmetic
// reference that rounds the exact double result to bf16 (RNE, flush-to-zero).
module tb_bf16_arith_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        out_valid;
  logic [15:0] out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bf16_arith_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out      (out)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_real(input logic [15:0] x);
    real r;
    if (x[14:7] == 8'h00) r = 0.0;
    else r = real'(128 + int'(x[6:0])) * pow2(int'(x[14:7]) - 134);
    if (x[15]) r = -r;
    return r;
  endfunction

  // Round an exactly-representable-in-double value to bf16.
  function automatic logic [15:0] from_real(input real r);
    logic [63:0] bits;
    int e, m, be;
    bits = $realtobits(r);
    if (r == 0.0) return {bits[63], 15'h0000};
    e = int'(bits[62:52]) - 1023;
    m = int'({1'b1, bits[51:45]});
    if (bits[44] && ((|bits[43:0]) || m[0])) m = m + 1;
    if (m == 256) begin
      m = 128;
      e = e + 1;
    end
    be = e + 127;
    if (be >= 255) return {bits[63], 15'h7F80};
    if (be <= 0) return {bits[63], 15'h0000};
    return {bits[63], 8'(be), 7'(m)};
  endfunction

  function automatic logic [15:0] ref_model(input logic [1:0] o, input logic [15:0] x,
                                            input logic [15:0] y);
    logic nx, ny, ix, iy, zx, zy, s;
    if (o == 2'b01) y[15] = ~y[15];
    nx = (x[14:7] == 8'hFF) && (x[6:0] != 0);
    ny = (y[14:7] == 8'hFF) && (y[6:0] != 0);
    ix = (x[14:7] == 8'hFF) && (x[6:0] == 0);
    iy = (y[14:7] == 8'hFF) && (y[6:0] == 0);
    zx = (x[14:7] == 8'h00);
    zy = (y[14:7] == 8'h00);
    s  = x[15] ^ y[15];
    if (nx || ny) return 16'h7FC0;
    if (o[1] == 1'b0) begin
      if (ix && iy && (x[15] != y[15])) return 16'h7FC0;
      if (ix) return {x[15], 15'h7F80};
      if (iy) return {y[15], 15'h7F80};
      return from_real(to_real(x) + to_real(y));
    end else if (o == 2'b10) begin
      if ((ix && zy) || (zx && iy)) return 16'h7FC0;
      if (ix || iy) return {s, 15'h7F80};
      if (zx || zy) return {s, 15'h0000};
      return from_real(to_real(x) * to_real(y));
    end else begin
      if ((zx && zy) || (ix && iy)) return 16'h7FC0;
      if (zy || ix) return {s, 15'h7F80};
      if (iy || zx) return {s, 15'h0000};
      return from_real(to_real(x) / to_real(y));
    end
  endfunction

  function automatic logic [15:0] rnd_bf16();
    logic [15:0] x;
    x = 16'($urandom);
    case ($urandom_range(15))
      0: x[14:7] = 8'h00;
      1: x[14:7] = 8'hFF;
      2: begin x[14:7] = 8'hFF; x[6:0] = 7'h00; end
      3: x[14:7] = 8'($urandom_range(8, 1));
      4: x[14:7] = 8'($urandom_range(254, 246));
      default: ;
    endcase
    return x;
  endfunction

  task automatic directed(input string tag, input logic [1:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    check(tag, out, exp);
    check({tag, "_vld"}, {15'b0, out_valid}, 16'h0001);
  endtask

  logic [15:0] exp_out, ra, rb;
  logic        exp_vld, rv;
  logic [1:0]  ro;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out", out, 16'h0000);
    check("rst_vld", {15'b0, out_valid}, 16'h0000);
    rst_n = 1'b1;

    directed("add_1p2",    2'b00, 16'h3F80, 16'h4000, 16'h4040);
    directed("sub_1m1",    2'b01, 16'h3F80, 16'h3F80, 16'h0000);
    directed("add_infni",  2'b00, 16'h7F80, 16'hFF80, 16'h7FC0);
    directed("mul_2x3",    2'b10, 16'h4000, 16'h4040, 16'h40C0);
    directed("mul_ovf",    2'b10, 16'h7F7F, 16'h4000, 16'h7F80);
    directed("div_1d3",    2'b11, 16'h3F80, 16'h4040, 16'h3EAB);
    directed("div_xd0",    2'b11, 16'h3F80, 16'h0000, 16'h7F80);
    directed("div_0d0",    2'b11, 16'h0000, 16'h0000, 16'h7FC0);
    directed("add_nzero",  2'b00, 16'h8000, 16'h8000, 16'h8000);
    directed("mul_0xinf",  2'b10, 16'h0000, 16'hFF80, 16'h7FC0);
    directed("mul_nzero",  2'b10, 16'hBF80, 16'h0001, 16'h8000);
    directed("div_xdinf",  2'b11, 16'hBF80, 16'h7F80, 16'h8000);
    directed("mul_nan",    2'b10, 16'h7FC1, 16'h3F80, 16'h7FC0);
    directed("add_sub_ftz", 2'b01, 16'h00C0, 16'h0080, 16'h0000);

    // Operands change with in_valid low: output must hold.
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'h4000;
    b = 16'h4000;
    @(negedge clk);
    check("hold_out", out, 16'h0000);
    check("hold_vld", {15'b0, out_valid}, 16'h0000);

    // Asynchronous reset mid-stream, between clock edges.
    directed("pre_rst",    2'b00, 16'h4000, 16'h4000, 16'h4080);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", out, 16'h0000);
    check("arst_vld", {15'b0, out_valid}, 16'h0000);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    exp_out = 16'h0000;
    exp_vld = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      check("rnd_out", out, exp_out);
      check("rnd_vld", {15'b0, out_valid}, {15'b0, exp_vld});
      rv = ($urandom_range(7) != 0);
      ro = 2'($urandom_range(3));
      ra = rnd_bf16();
      rb = rnd_bf16();
      if ($urandom_range(3) == 0) rb[14:7] = ra[14:7] + 8'($urandom_range(2)) - 8'd1;
      in_valid = rv;
      op = ro;
      a = ra;
      b = rb;
      if (rv) exp_out = ref_model(ro, ra, rb);
      exp_vld = rv;
    end
    @(negedge clk);
    check("rnd_out_last", out, exp_out);
    check("rnd_vld_last", {15'b0, out_valid}, {15'b0, exp_vld});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
